// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared FSM state type and synchroniser depth for the SPI slave core
package spi_slave_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one async input with rise/fall pulses on the synced level
module spi_sync_edge
  import spi_slave_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic q_d;
  // Shift the async input through the synchroniser and keep the previous synced level
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= {SYNC_STAGES{RST_VAL}};
      q_d  <= RST_VAL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      q_d  <= sync[SYNC_STAGES-1];
    end
  assign q    = sync[SYNC_STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;
endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core: SPI slave (all CPOL/CPHA modes) with tx holding register; SPI_SLAVE_FRAME_CNT_EN adds frame_cnt
module spi_slave_core #(
  parameter int DATA_W = 8,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
`ifdef SPI_SLAVE_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);
  import spi_slave_pkg::*;
  localparam int CNT_W = $clog2(DATA_W);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr, hold, rx_next, tx_reload;
  logic hold_full;
  logic sclk_rise, sclk_fall, mosi_s, ss_s, ss_fall;
  logic unused_sclk_s, unused_mosi_rise, unused_mosi_fall, unused_ss_rise;
  logic lead, trail, sample, shift_e, last, accept;
  spi_sync_edge #(.RST_VAL(1'(CPOL))) u_sync_sclk (
    .clk(clk), .reset(reset), .d(sclk), .q(unused_sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(mosi), .q(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
  );
  // ss_n chain resets low so a select already held low at reset release is not seen as a new frame
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_ss (
    .clk(clk), .reset(reset), .d(ss_n), .q(ss_s), .rise(unused_ss_rise), .fall(ss_fall)
  );
  assign lead      = (CPOL != 0) ? sclk_fall : sclk_rise;
  assign trail     = (CPOL != 0) ? sclk_rise : sclk_fall;
  assign sample    = (CPHA != 0) ? trail : lead;
  assign shift_e   = (CPHA != 0) ? lead : trail;
  assign last      = cnt == CNT_W'(DATA_W - 1);
  assign accept    = tx_valid && !hold_full;
  assign rx_next   = {rx_sr[DATA_W-2:0], mosi_s};
  assign tx_reload = hold_full ? hold : '0;
  assign tx_ready  = !hold_full;
  assign busy      = state != IDLE;
  assign miso      = (state != IDLE) && tx_sr[DATA_W-1];
  // Frame FSM: select handling, bit counting, shifting both directions and holding-register reloads.
  // A shift edge seen with cnt==0 is the one right after a (re)load, so it must keep the fresh MSB.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (accept) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      if (ss_s) begin
        state <= IDLE;
        cnt   <= '0;
        rx_sr <= '0;
        tx_sr <= '0;
      end else if (state == IDLE) begin
        state <= ss_fall ? LOAD : IDLE;
      end else if (state == LOAD) begin
        state     <= SHIFT;
        cnt       <= '0;
        tx_sr     <= tx_reload;
        hold_full <= accept;
      end else if (sample) begin
        rx_sr <= rx_next;
        cnt   <= last ? '0 : cnt + CNT_W'(1);
        if (last) begin
          rx_data   <= rx_next;
          rx_valid  <= 1'b1;
          tx_sr     <= tx_reload;
          hold_full <= accept;
        end
      end else if (shift_e && cnt != '0) begin
        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
      end
    end
`ifdef SPI_SLAVE_FRAME_CNT_EN
  // Count completed frames, wrapping naturally at 16 bits
  always_ff @(posedge clk or posedge reset)
    if (reset) frame_cnt <= '0;
    else if (rx_valid) frame_cnt <= frame_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_spi_slave_core.sv
// tb_spi_slave_core: four 8-bit mode instances plus one 16-bit mode-0 instance against a frame-level model
module tb_spi_slave_core;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] sclk, mosi, ss_n, miso, tx_valid, tx_ready, rx_valid, busy;
  logic [7:0] tx8[4];
  logic [7:0] rx8[4];
  logic [15:0] tx16, rx16;
`ifdef SPI_SLAVE_FRAME_CNT_EN
  logic [15:0] fc[5];
`endif
  int rvc[5];
  int n_cmp, n_err;
  logic [15:0] txq[5][$];
  logic [15:0] last_rx[5];
  int fc_exp[5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_m
    spi_slave_core #(.DATA_W(8), .CPOL(g / 2), .CPHA(g % 2)) u_dut (
      .clk(clk), .reset(reset), .sclk(sclk[g]), .mosi(mosi[g]), .ss_n(ss_n[g]), .miso(miso[g]),
      .tx_data(tx8[g]), .tx_valid(tx_valid[g]), .tx_ready(tx_ready[g]),
      .rx_data(rx8[g]), .rx_valid(rx_valid[g]), .busy(busy[g])
`ifdef SPI_SLAVE_FRAME_CNT_EN
      , .frame_cnt(fc[g])
`endif
    );
  end

  spi_slave_core #(.DATA_W(16), .CPOL(0), .CPHA(0)) u_dut16 (
    .clk(clk), .reset(reset), .sclk(sclk[4]), .mosi(mosi[4]), .ss_n(ss_n[4]), .miso(miso[4]),
    .tx_data(tx16), .tx_valid(tx_valid[4]), .tx_ready(tx_ready[4]),
    .rx_data(rx16), .rx_valid(rx_valid[4]), .busy(busy[4])
`ifdef SPI_SLAVE_FRAME_CNT_EN
    , .frame_cnt(fc[4])
`endif
  );

  always @(posedge clk)
    for (int i = 0; i < 5; i++) if (rx_valid[i]) rvc[i] <= rvc[i] + 1;

  function automatic int wd(input int k);
    return (k == 4) ? 16 : 8;
  endfunction

  function automatic logic [15:0] mask(input int k);
    return (k == 4) ? 16'hFFFF : 16'h00FF;
  endfunction

  function automatic logic cpol(input int k);
    return (k < 4) ? k[1] : 1'b0;
  endfunction

  function automatic logic cpha(input int k);
    return (k < 4) ? k[0] : 1'b0;
  endfunction

  function automatic logic [15:0] rxd(input int k);
    return (k == 4) ? rx16 : {8'h00, rx8[k]};
  endfunction

  // Every transfer of the holding register into the shifter consumes one queued word, or zeros if none
  function automatic logic [15:0] pop(input int k);
    if (txq[k].size() != 0) return txq[k].pop_front();
    return 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_h();
    repeat (8) @(negedge clk);
  endtask

  task automatic load_tx(input int k, input logic [15:0] t);
    int n;
    n = 0;
    while (!tx_ready[k] && n < 64) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("k%0d tx_ready_wait", k), 32'(tx_ready[k]), 32'd1);
    if (tx_ready[k]) begin
      if (k == 4) tx16 = t;
      else tx8[k] = t[7:0];
      tx_valid[k] = 1'b1;
      @(negedge clk);
      tx_valid[k] = 1'b0;
      txq[k].push_back(t & mask(k));
    end
  endtask

  // Master side: n bits of w, MSB first, in the instance's mode; returns the bits seen on miso
  task automatic xfer(input int k, input int n, input logic [15:0] w, output logic [15:0] got);
    got = '0;
    for (int b = wd(k) - 1; b >= wd(k) - n; b--) begin
      if (!cpha(k)) begin
        mosi[k] = w[b];
        wait_h();
        sclk[k] = ~cpol(k);
        got = {got[14:0], miso[k]};
        wait_h();
        sclk[k] = cpol(k);
      end else begin
        sclk[k] = ~cpol(k);
        mosi[k] = w[b];
        wait_h();
        sclk[k] = cpol(k);
        got = {got[14:0], miso[k]};
        wait_h();
      end
    end
    wait_h();
  endtask

  // One ss_n window of nw words of n bits; optional tx load just after the window opens
  task automatic window(input int k, input int n, input int nw, input logic [15:0] w0, input logic [15:0] w1,
                        input bit ld, input logic [15:0] t1);
    logic [15:0] cur, got, w;
    int c0;
    ss_n[k] = 1'b0;
    cur = pop(k);
    wait_h();
    check($sformatf("k%0d busy", k), 32'(busy[k]), 32'd1);
    if (ld) load_tx(k, t1);
    for (int j = 0; j < nw; j++) begin
      w = ((j == 0) ? w0 : w1) & mask(k);
      c0 = rvc[k];
      xfer(k, n, w, got);
      if (n == wd(k)) begin
        check($sformatf("k%0d miso_word", k), 32'(got), 32'(cur));
        cur = pop(k);
        last_rx[k] = w;
        fc_exp[k]++;
      end
      check($sformatf("k%0d rx_pulses", k), 32'(rvc[k] - c0), (n == wd(k)) ? 32'd1 : 32'd0);
      check($sformatf("k%0d rx_data", k), 32'(rxd(k)), 32'(last_rx[k]));
    end
    ss_n[k] = 1'b1;
    wait_h();
    wait_h();
    check($sformatf("k%0d busy_idle", k), 32'(busy[k]), 32'd0);
    check($sformatf("k%0d miso_idle", k), 32'(miso[k]), 32'd0);
`ifdef SPI_SLAVE_FRAME_CNT_EN
    check($sformatf("k%0d frame_cnt", k), 32'(fc[k]), 32'(fc_exp[k] & 16'hFFFF));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s k%0d rx_data", tag, k), 32'(rxd(k)), 32'd0);
      check($sformatf("%s k%0d rx_valid", tag, k), 32'(rx_valid[k]), 32'd0);
      check($sformatf("%s k%0d busy", tag, k), 32'(busy[k]), 32'd0);
      check($sformatf("%s k%0d tx_ready", tag, k), 32'(tx_ready[k]), 32'd1);
      check($sformatf("%s k%0d miso", tag, k), 32'(miso[k]), 32'd0);
`ifdef SPI_SLAVE_FRAME_CNT_EN
      check($sformatf("%s k%0d frame_cnt", tag, k), 32'(fc[k]), 32'd0);
`endif
    end
  endtask

  initial begin
    logic [15:0] got;
    int c0;
    reset = 1'b1;
    ss_n = '1;
    mosi = '0;
    tx_valid = '0;
    tx16 = '0;
    for (int k = 0; k < 5; k++) begin
      sclk[k] = cpol(k);
      last_rx[k] = '0;
      fc_exp[k] = 0;
      if (k < 4) tx8[k] = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_reset_outputs("after_reset");

    load_tx(0, 16'h003C);
    window(0, 8, 1, 16'h00A5, 16'h0000, 1'b0, 16'h0000);

    for (int k = 0; k < 4; k++) begin
      load_tx(k, 16'h007E);
      window(k, 8, 1, 16'h0081, 16'h0000, 1'b0, 16'h0000);
    end

    load_tx(0, 16'h00AA);
    window(0, 8, 2, 16'h0012, 16'h0034, 1'b1, 16'h0055);
    load_tx(3, 16'h00AA);
    window(3, 8, 2, 16'h0012, 16'h0034, 1'b1, 16'h0055);

    load_tx(1, 16'h0033);
    window(1, 5, 1, 16'h00C3, 16'h0000, 1'b0, 16'h0000);
    window(1, 8, 1, 16'h00F0, 16'h0000, 1'b0, 16'h0000);
    window(2, 5, 1, 16'h005A, 16'h0000, 1'b0, 16'h0000);
    window(2, 8, 1, 16'h00F0, 16'h0000, 1'b0, 16'h0000);

    window(2, 8, 1, 16'h0096, 16'h0000, 1'b0, 16'h0000);
    check("k2 tx_ready_idle", 32'(tx_ready[2]), 32'd1);

    load_tx(4, 16'h1357);
    window(4, 16, 2, 16'hBEEF, 16'hBEEF, 1'b0, 16'h0000);
    window(4, 16, 1, 16'hBEEF, 16'h0000, 1'b0, 16'h0000);

    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 1) == 1) load_tx(k, 16'($urandom));
        window(k, wd(k), int'($urandom_range(1, 2)), 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)), 16'($urandom));
      end

    ss_n[4] = 1'b0;
    wait_h();
    xfer(4, 7, 16'h1234, got);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_frame_reset");
    for (int k = 0; k < 5; k++) begin
      txq[k].delete();
      last_rx[k] = '0;
      fc_exp[k] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    c0 = rvc[4];
    wait_h();
    xfer(4, 16, 16'hFFFF, got);
    check("k4 no_frame_without_fall", 32'(rvc[4] - c0), 32'd0);
    check("k4 busy_without_fall", 32'(busy[4]), 32'd0);
    check("k4 rx_data_without_fall", 32'(rx16), 32'd0);
    ss_n[4] = 1'b1;
    wait_h();
    wait_h();
    window(4, 16, 1, 16'hC0DE, 16'h0000, 1'b0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
